// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the two-master Wishbone arbiter.
//   owner_e  : who currently holds the shared slave port
//   GRANT_I  : index of the instruction master (value kept in the 'last' register)
//   GRANT_D  : index of the data master
// ---------------------------------------------------------------------------
package wb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } owner_e;

   localparam logic GRANT_I = 1'b0;
   localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/wb_watchdog.sv
// ---------------------------------------------------------------------------
// wb_watchdog
// Counts cycles in which a transfer is outstanding without any response and
// flags expiry once TIMEOUT such cycles have gone by.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i          : a strobe is outstanding this cycle with no ack/err
//   clr_i         : response seen or no transfer in progress; clears the count
//   expire_o      : count has reached TIMEOUT and nothing is clearing it
// TIMEOUT = 0 disables the watchdog; expire_o then stays low.
// ---------------------------------------------------------------------------
module wb_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic clr_i,
   output logic expire_o
);

   // A zero TIMEOUT would give a zero-width counter, so keep at least one bit.
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Expiry is suppressed whenever a clear is pending in the same cycle, which
   // is how an ack landing exactly on the expiry cycle wins over the timeout.
   always_comb begin
      expire_o = (TIMEOUT != 0) && (cnt_q == LIMIT) && !clr_i;
      cnt_d    = cnt_q;
      if (clr_i || expire_o) begin
         cnt_d = '0;
      end else if (en_i && (TIMEOUT != 0)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wb_arb2.sv
// ---------------------------------------------------------------------------
// wb_arb2
// Round-robin arbiter sharing one Wishbone classic slave port between the
// instruction master (read-only) and the data master. A grant lasts for the
// owner's whole cyc burst; a watchdog aborts transfers the slave never answers.
// Ports:
//   wb_clk_i, wb_rst_ni        : clock, asynchronous active-low reset
//   iwbm_*                     : instruction master request / response
//   dwbm_*                     : data master request / response
//   wbs_*                      : shared slave request / response
// ---------------------------------------------------------------------------
module wb_arb2 #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_ni,
   input  logic [AW-1:0]     iwbm_adr_i,
   input  logic              iwbm_stb_i,
   input  logic              iwbm_cyc_i,
   output logic [DW-1:0]     iwbm_dat_o,
   output logic              iwbm_ack_o,
   output logic              iwbm_err_o,
   input  logic [AW-1:0]     dwbm_adr_i,
   input  logic [DW-1:0]     dwbm_dat_i,
   input  logic [DW/8-1:0]   dwbm_sel_i,
   input  logic              dwbm_we_i,
   input  logic              dwbm_stb_i,
   input  logic              dwbm_cyc_i,
   output logic [DW-1:0]     dwbm_dat_o,
   output logic              dwbm_ack_o,
   output logic              dwbm_err_o,
   output logic [AW-1:0]     wbs_adr_o,
   output logic [DW-1:0]     wbs_dat_o,
   output logic [DW/8-1:0]   wbs_sel_o,
   output logic              wbs_we_o,
   output logic              wbs_stb_o,
   output logic              wbs_cyc_o,
   input  logic [DW-1:0]     wbs_dat_i,
   input  logic              wbs_ack_i,
   input  logic              wbs_err_i
);

   import wb_pkg::*;

   owner_e state_q;
   logic   last_q;
   logic   reqI;
   logic   reqD;
   logic   ownerCyc;
   logic   ownerStb;
   logic   wdEn;
   logic   wdClr;
   logic   expire;

   assign reqI = iwbm_cyc_i & iwbm_stb_i;
   assign reqD = dwbm_cyc_i & dwbm_stb_i;

   // Owner FSM. Arbitration only happens from IDLE, so every handover passes
   // through at least one IDLE cycle. On a tie the master that did not win
   // last time is granted; reset leaves last at D so the first tie goes to I.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q <= IDLE;
         last_q  <= GRANT_D;
      end else begin
         case (state_q)
            IDLE: begin
               if (reqI && (!reqD || (last_q == GRANT_D))) begin
                  state_q <= GNT_I;
                  last_q  <= GRANT_I;
               end else if (reqD) begin
                  state_q <= GNT_D;
                  last_q  <= GRANT_D;
               end
            end
            GNT_I: if (!iwbm_cyc_i) state_q <= IDLE;
            GNT_D: if (!dwbm_cyc_i) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Raw cyc/stb of whichever master owns the port, before any watchdog abort.
   always_comb begin
      ownerCyc = 1'b0;
      ownerStb = 1'b0;
      case (state_q)
         GNT_I: begin
            ownerCyc = iwbm_cyc_i;
            ownerStb = iwbm_stb_i;
         end
         GNT_D: begin
            ownerCyc = dwbm_cyc_i;
            ownerStb = dwbm_stb_i;
         end
         default: ;
      endcase
   end

   // The watchdog counts unanswered strobe cycles and is cleared by any slave
   // response or whenever there is no live owner burst (IDLE or cyc dropped).
   assign wdEn  = ownerStb & ~wbs_ack_i & ~wbs_err_i;
   assign wdClr = ~ownerCyc | wbs_ack_i | wbs_err_i;

   wb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk_i    (wb_clk_i),
      .rst_ni   (wb_rst_ni),
      .en_i     (wdEn),
      .clr_i    (wdClr),
      .expire_o (expire)
   );

   // Read data is broadcast; only the owner sees ack/err.
   assign iwbm_dat_o = wbs_dat_i;
   assign dwbm_dat_o = wbs_dat_i;

   // Request mux and response routing. On expiry the slave cycle is dropped
   // and the owner gets a one-cycle err in place of the missing ack.
   always_comb begin
      wbs_adr_o  = '0;
      wbs_dat_o  = '0;
      wbs_sel_o  = '0;
      wbs_we_o   = 1'b0;
      wbs_cyc_o  = 1'b0;
      wbs_stb_o  = 1'b0;
      iwbm_ack_o = 1'b0;
      iwbm_err_o = 1'b0;
      dwbm_ack_o = 1'b0;
      dwbm_err_o = 1'b0;
      case (state_q)
         GNT_I: begin
            wbs_adr_o  = iwbm_adr_i;
            wbs_sel_o  = '1;
            wbs_cyc_o  = iwbm_cyc_i & ~expire;
            wbs_stb_o  = iwbm_stb_i & ~expire;
            iwbm_ack_o = wbs_ack_i;
            iwbm_err_o = wbs_err_i | expire;
         end
         GNT_D: begin
            wbs_adr_o  = dwbm_adr_i;
            wbs_dat_o  = dwbm_dat_i;
            wbs_sel_o  = dwbm_sel_i;
            wbs_we_o   = dwbm_we_i;
            wbs_cyc_o  = dwbm_cyc_i & ~expire;
            wbs_stb_o  = dwbm_stb_i & ~expire;
            dwbm_ack_o = wbs_ack_i;
            dwbm_err_o = wbs_err_i | expire;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_wb_arb2.sv
// ---------------------------------------------------------------------------
// tb_wb_arb2
// Self-checking bench for wb_arb2 (TIMEOUT = 8). A behavioural model of the
// arbitration rules predicts every output each cycle; directed scenarios add
// hand-computed expectations at the interesting cycles.
// ---------------------------------------------------------------------------
module tb_wb_arb2;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [31:0]   iwbm_adr_i = '0;
   logic          iwbm_stb_i = 1'b0;
   logic          iwbm_cyc_i = 1'b0;
   logic [31:0]   iwbm_dat_o;
   logic          iwbm_ack_o;
   logic          iwbm_err_o;
   logic [31:0]   dwbm_adr_i = '0;
   logic [31:0]   dwbm_dat_i = '0;
   logic [3:0]    dwbm_sel_i = '0;
   logic          dwbm_we_i = 1'b0;
   logic          dwbm_stb_i = 1'b0;
   logic          dwbm_cyc_i = 1'b0;
   logic [31:0]   dwbm_dat_o;
   logic          dwbm_ack_o;
   logic          dwbm_err_o;
   logic [31:0]   wbs_adr_o;
   logic [31:0]   wbs_dat_o;
   logic [3:0]    wbs_sel_o;
   logic          wbs_we_o;
   logic          wbs_stb_o;
   logic          wbs_cyc_o;
   logic [31:0]   wbs_dat_i = '0;
   logic          wbs_ack_i = 1'b0;
   logic          wbs_err_i = 1'b0;

   int testsRun = 0;
   int testsFailed = 0;

   always #5 clk = ~clk;

   wb_arb2 #(
      .AW      (AW),
      .DW      (DW),
      .TIMEOUT (TO)
   ) dut (
      .wb_clk_i   (clk),
      .wb_rst_ni  (rst_n),
      .iwbm_adr_i (iwbm_adr_i),
      .iwbm_stb_i (iwbm_stb_i),
      .iwbm_cyc_i (iwbm_cyc_i),
      .iwbm_dat_o (iwbm_dat_o),
      .iwbm_ack_o (iwbm_ack_o),
      .iwbm_err_o (iwbm_err_o),
      .dwbm_adr_i (dwbm_adr_i),
      .dwbm_dat_i (dwbm_dat_i),
      .dwbm_sel_i (dwbm_sel_i),
      .dwbm_we_i  (dwbm_we_i),
      .dwbm_stb_i (dwbm_stb_i),
      .dwbm_cyc_i (dwbm_cyc_i),
      .dwbm_dat_o (dwbm_dat_o),
      .dwbm_ack_o (dwbm_ack_o),
      .dwbm_err_o (dwbm_err_o),
      .wbs_adr_o  (wbs_adr_o),
      .wbs_dat_o  (wbs_dat_o),
      .wbs_sel_o  (wbs_sel_o),
      .wbs_we_o   (wbs_we_o),
      .wbs_stb_o  (wbs_stb_o),
      .wbs_cyc_o  (wbs_cyc_o),
      .wbs_dat_i  (wbs_dat_i),
      .wbs_ack_i  (wbs_ack_i),
      .wbs_err_i  (wbs_err_i)
   );

   // Common comparison: counts every check and reports mismatches.
   task automatic checkOutput(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drives both master request buses in one go.
   task automatic applyStimulus(input logic iReq, input logic [31:0] iAdr,
                                input logic dCyc, input logic dStb, input logic dWe,
                                input logic [31:0] dAdr, input logic [31:0] dDat,
                                input logic [3:0] dSel);
      iwbm_cyc_i = iReq;
      iwbm_stb_i = iReq;
      iwbm_adr_i = iAdr;
      dwbm_cyc_i = dCyc;
      dwbm_stb_i = dStb;
      dwbm_we_i  = dWe;
      dwbm_adr_i = dAdr;
      dwbm_dat_i = dDat;
      dwbm_sel_i = dSel;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] allOutputs();
      return 128'({wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_stb_o, wbs_cyc_o,
                   iwbm_ack_o, iwbm_err_o, dwbm_ack_o, dwbm_err_o});
   endfunction

   // ---------------- behavioural model ----------------
   // ownerM: 0 nobody, 1 instruction, 2 data. lastM: last winner (1 or 2).
   // stallM: unanswered strobe cycles in the current burst.
   int          ownerM = 0;
   int          lastM = 2;
   int          stallM = 0;
   int          nextOwner;
   int          nextLast;
   int          nextStall;
   logic        ownerCycM;
   logic        ownerStbM;
   logic        expM;
   logic [70:0] expSlave;
   logic [1:0]  expIResp;
   logic [1:0]  expDResp;

   always_comb begin
      ownerCycM = (ownerM == 1) ? iwbm_cyc_i : (ownerM == 2) ? dwbm_cyc_i : 1'b0;
      ownerStbM = (ownerM == 1) ? iwbm_stb_i : (ownerM == 2) ? dwbm_stb_i : 1'b0;
      expM = (ownerM != 0) && ownerCycM && (stallM == TO) && !wbs_ack_i && !wbs_err_i;

      nextOwner = ownerM;
      nextLast  = lastM;
      if (ownerM == 0) begin
         if (iwbm_cyc_i && iwbm_stb_i && (!(dwbm_cyc_i && dwbm_stb_i) || lastM == 2))
            nextOwner = 1;
         else if (dwbm_cyc_i && dwbm_stb_i)
            nextOwner = 2;
         if (nextOwner != 0) nextLast = nextOwner;
      end else if (!ownerCycM) begin
         nextOwner = 0;
      end

      nextStall = stallM;
      if (ownerM == 0 || !ownerCycM || wbs_ack_i || wbs_err_i || expM)
         nextStall = 0;
      else if (ownerStbM)
         nextStall = stallM + 1;

      expSlave = '0;
      expIResp = '0;
      expDResp = '0;
      if (ownerM == 1) begin
         expSlave = {iwbm_adr_i, 32'h0, 4'hF, 1'b0, iwbm_cyc_i & ~expM, iwbm_stb_i & ~expM};
         expIResp = {wbs_ack_i, wbs_err_i | expM};
      end else if (ownerM == 2) begin
         expSlave = {dwbm_adr_i, dwbm_dat_i, dwbm_sel_i, dwbm_we_i,
                     dwbm_cyc_i & ~expM, dwbm_stb_i & ~expM};
         expDResp = {wbs_ack_i, wbs_err_i | expM};
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ownerM <= 0;
         lastM  <= 2;
         stallM <= 0;
      end else begin
         ownerM <= nextOwner;
         lastM  <= nextLast;
         stallM <= nextStall;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      checkOutput("model slave request",
                  128'({wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o}),
                  128'(expSlave));
      checkOutput("model imaster resp", 128'({iwbm_ack_o, iwbm_err_o}), 128'(expIResp));
      checkOutput("model dmaster resp", 128'({dwbm_ack_o, dwbm_err_o}), 128'(expDResp));
      checkOutput("model read data", 128'({iwbm_dat_o, dwbm_dat_o}),
                  128'({wbs_dat_i, wbs_dat_i}));
   end

   // ---------------- directed scenarios ----------------
   task automatic doReset();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      wbs_ack_i = 1'b0;
      wbs_err_i = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("reset outputs zero", allOutputs(), 128'(0));
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL global time limit: got no finish, expected finish");
      $fatal(1, "[TB] time limit");
   end

   initial begin
      doReset();

      // Single instruction read with two wait states.
      wbs_dat_i = 32'hDEADBEEF;
      tick();
      applyStimulus(1'b1, 32'h0000_0010, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      checkOutput("t1 stb before grant", 128'(wbs_stb_o), 128'(0));
      tick();
      @(negedge clk);
      checkOutput("t1 stb one cycle after", 128'(wbs_stb_o), 128'(1));
      checkOutput("t1 slave adr", 128'(wbs_adr_o), 128'(32'h10));
      checkOutput("t1 sel/we", 128'({wbs_sel_o, wbs_we_o}), 128'(5'b11110));
      tick();
      @(negedge clk);
      checkOutput("t1 no ack in wait", 128'(iwbm_ack_o), 128'(0));
      tick();
      wbs_ack_i = 1'b1;
      @(negedge clk);
      checkOutput("t1 iack with slave ack", 128'(iwbm_ack_o), 128'(1));
      checkOutput("t1 idat", 128'(iwbm_dat_o), 128'(32'hDEADBEEF));
      checkOutput("t1 dack stays low", 128'(dwbm_ack_o), 128'(0));
      tick();
      wbs_ack_i = 1'b0;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      tick();

      // Tie after reset: instruction first, one IDLE cycle, then data write.
      doReset();
      wbs_dat_i = 32'h0BAD_F00D;
      tick();
      applyStimulus(1'b1, 32'h20, 1'b1, 1'b1, 1'b1, 32'h30, 32'h1234_5678, 4'hF);
      tick();
      wbs_ack_i = 1'b1;
      @(negedge clk);
      checkOutput("t2 tie goes to imaster", 128'(wbs_adr_o), 128'(32'h20));
      checkOutput("t2 iack", 128'({iwbm_ack_o, dwbm_ack_o}), 128'(2'b10));
      tick();
      wbs_ack_i = 1'b0;
      iwbm_cyc_i = 1'b0;
      iwbm_stb_i = 1'b0;
      @(negedge clk);
      checkOutput("t2 cyc low after drop", 128'(wbs_cyc_o), 128'(0));
      tick();
      @(negedge clk);
      checkOutput("t2 idle gap", 128'(wbs_cyc_o), 128'(0));
      tick();
      wbs_ack_i = 1'b1;
      @(negedge clk);
      checkOutput("t2 dwrite request",
                  128'({wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o}),
                  128'({32'h30, 32'h1234_5678, 4'hF, 1'b1, 1'b1}));
      checkOutput("t2 dack", 128'(dwbm_ack_o), 128'(1));
      tick();
      wbs_ack_i = 1'b0;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      tick();

      // Grant held across four data beats while the instruction master waits.
      tick();
      applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1, 32'h50, 32'hA5A5_0000, 4'h3);
      tick();
      iwbm_cyc_i = 1'b1;
      iwbm_stb_i = 1'b1;
      iwbm_adr_i = 32'h60;
      for (int i = 0; i < 4; i++) begin
         dwbm_stb_i = 1'b1;
         dwbm_dat_i = 32'hA5A5_0000 + i;
         wbs_ack_i = 1'b1;
         @(negedge clk);
         checkOutput("t3 beat owner", 128'({wbs_adr_o, dwbm_ack_o, iwbm_ack_o}),
                     128'({32'h50, 1'b1, 1'b0}));
         tick();
         dwbm_stb_i = 1'b0;
         wbs_ack_i = 1'b0;
         @(negedge clk);
         checkOutput("t3 held between beats", 128'({wbs_adr_o, wbs_cyc_o}),
                     128'({32'h50, 1'b1}));
         tick();
      end
      dwbm_cyc_i = 1'b0;
      @(negedge clk);
      checkOutput("t3 cyc released", 128'(wbs_cyc_o), 128'(0));
      tick();
      @(negedge clk);
      checkOutput("t3 idle gap", 128'(wbs_cyc_o), 128'(0));
      tick();
      wbs_ack_i = 1'b1;
      @(negedge clk);
      checkOutput("t3 imaster granted after",
                  128'({wbs_adr_o, wbs_sel_o, wbs_we_o, iwbm_ack_o}),
                  128'({32'h60, 4'hF, 1'b0, 1'b1}));
      tick();
      wbs_ack_i = 1'b0;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      tick();

      // Watchdog expiry: err in the ninth unanswered strobe cycle.
      applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0, 32'h70, '0, 4'hF);
      tick();
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (k < 9) begin
            checkOutput("t4 no early err", 128'({dwbm_err_o, wbs_stb_o}), 128'(2'b01));
         end else begin
            checkOutput("t4 err at expiry", 128'({dwbm_err_o, iwbm_err_o}), 128'(2'b10));
            checkOutput("t4 cyc/stb forced low", 128'({wbs_cyc_o, wbs_stb_o}), 128'(0));
         end
         tick();
      end
      dwbm_cyc_i = 1'b0;
      dwbm_stb_i = 1'b0;
      @(negedge clk);
      checkOutput("t4 err single pulse", 128'(dwbm_err_o), 128'(0));
      tick();
      tick();

      // Ack lands exactly on the expiry cycle.
      applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0, 32'h80, '0, 4'hF);
      tick();
      for (int k = 1; k <= 9; k++) begin
         if (k == 9) wbs_ack_i = 1'b1;
         @(negedge clk);
         if (k == 9)
            checkOutput("t5 ack beats expiry", 128'({dwbm_ack_o, dwbm_err_o}), 128'(2'b10));
         tick();
      end
      wbs_ack_i = 1'b0;
      @(negedge clk);
      checkOutput("t5 counter cleared", 128'({dwbm_err_o, wbs_stb_o}), 128'(2'b01));
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      tick();
      tick();

      // Reset in the middle of an instruction transfer.
      applyStimulus(1'b1, 32'h90, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      tick();
      tick();
      wbs_ack_i = 1'b1;
      #1;
      checkOutput("t6 ack before reset", 128'(iwbm_ack_o), 128'(1));
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("t6 outputs zero at reset", allOutputs(), 128'(0));
      tick();
      wbs_ack_i = 1'b0;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      rst_n = 1'b1;
      tick();
      applyStimulus(1'b1, 32'h44, 1'b1, 1'b1, 1'b0, 32'h88, '0, 4'hF);
      tick();
      @(negedge clk);
      checkOutput("t6 tie after reset to imaster", 128'(wbs_adr_o), 128'(32'h44));
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/wb_arb2.md
# wb_arb2

Two-master Wishbone classic arbiter that shares one slave port between the MIPS32r1 instruction master and data master, for example so that both can reach the boot ROM through a single interconnect slot. Arbitration is round-robin, and the grant is held for a master's whole `cyc` burst. A watchdog terminates any transfer that the slave never acknowledges, returning `err` to the owning master. The block sits between the `mips32r1_wb` master ports and the intercon slave port.

## Interface
Parameters:
- `AW`, 32: address width.
- `DW`, 32: data width. `sel` width is `DW/8`.
- `TIMEOUT`, 255: cycles without `ack` before the watchdog fires. A value of 0 disables the watchdog.

Ports:
- `wb_clk_i` in 1: the single clock.
- `wb_rst_ni` in 1: reset, asynchronous assert, active-low.
- `iwbm_adr_i` in AW; `iwbm_stb_i`, `iwbm_cyc_i` in 1: instruction master request. This master is read-only.
- `iwbm_dat_o` out DW; `iwbm_ack_o`, `iwbm_err_o` out 1: instruction master response.
- `dwbm_adr_i` in AW; `dwbm_dat_i` in DW; `dwbm_sel_i` in DW/8; `dwbm_we_i`, `dwbm_stb_i`, `dwbm_cyc_i` in 1: data master request.
- `dwbm_dat_o` out DW; `dwbm_ack_o`, `dwbm_err_o` out 1: data master response.
- `wbs_adr_o` out AW; `wbs_dat_o` out DW; `wbs_sel_o` out DW/8; `wbs_we_o`, `wbs_stb_o`, `wbs_cyc_o` out 1: shared slave request.
- `wbs_dat_i` in DW; `wbs_ack_i`, `wbs_err_i` in 1: shared slave response.

## Operation
- **Owner state.** `IDLE`, `GNT_I`, `GNT_D`, held in a register. `last` is a 1-bit register recording the most recent grant.
- **Request.** A master is requesting when its `cyc` and `stb` are both high.
- **From `IDLE`.**
  - Only one master requesting: grant that master.
  - Both requesting: grant the master that is not `last`.
  - `last` is updated on every grant.
- **From `GNT_x`.** Return to `IDLE` on the first edge at which master x's `cyc` is low. The grant is never preempted while `cyc` is high, including across multiple `stb` beats.
- **Slave request mux.**
  - The granted master's `adr`, `dat`, `sel`, `we`, `cyc` and `stb` drive the slave outputs.
  - When the instruction master is granted: `wbs_we_o`=0 and `wbs_sel_o`=all ones.
  - In `IDLE`, all slave outputs are 0.
- **Response routing.**
  - `wbs_dat_i` is broadcast to both `iwbm_dat_o` and `dwbm_dat_o`.
  - `ack` and `err` go only to the granted master. The non-granted master always sees 0.
- **Watchdog.**
  - A counter of width `$clog2(TIMEOUT+1)` increments on each cycle in which the state is `GNT_x`, `wbs_stb_o`=1, and `wbs_ack_i` and `wbs_err_i` are both 0.
  - The counter clears on `ack`, on `err`, or when leaving `GNT_x`.
  - When the counter equals `TIMEOUT`, in that same cycle:
    - pulse `err` to the owner for one cycle;
    - force `wbs_cyc_o` and `wbs_stb_o` to 0;
    - clear the counter.
  - The grant is then released through the normal `cyc`-low rule.
- **Slave error.** `wbs_err_i` passes through to the owner unchanged.

## Timing
- **Reset values.** State=`IDLE`, `last`=D so that the first tie goes to instruction fetch, counter=0. Every slave output, every `ack` output and every `err` output is 0.
- **Grant latency.** There is one cycle from request to slave `stb`. A request first seen at edge N gives the slave `stb` from cycle N+1.
- **Slave-to-master path.** `ack`, `err` and data are combinational, with zero added latency.
- **Master-to-slave path.** Combinational while granted.
- **Handover.** After the owner drops `cyc` there is at least one `IDLE` cycle before the other master is granted. The minimum gap between owners is therefore 1 cycle.
- **Simultaneous events.**
  - `ack` and watchdog expiry in the same cycle: `ack` wins, no `err` is raised, and the counter clears.
  - New request arriving in the cycle the owner drops `cyc`: it is arbitrated on the following edge from `IDLE`.
- **Reset mid-transfer.** All outputs go to 0 asynchronously, and no `ack` is delivered for the aborted beat.

## Structure
- A shared package `wb_pkg` holds:
  - the owner-state enum `{IDLE, GNT_I, GNT_D}`;
  - the grant-index constants `GRANT_I`=0 and `GRANT_D`=1.
- One sub-module is natural: `wb_watchdog`, the parameterised timeout counter. Its ports are enable, clear and `expire`.
- The arbiter FSM and the muxes stay in `wb_arb2`.

## Test plan
1. **Single master read.** Instruction-master read of 0x0000_0010, slave acks after 2 wait states -> `wbs_stb_o` rises 1 cycle after request, `iwbm_ack_o` coincides with `wbs_ack_i`, `iwbm_dat_o`=0xDEADBEEF, `dwbm_ack_o` stays 0.
2. **Tie after reset.** Both masters request in the same cycle after reset -> instruction master granted first. After it drops `cyc`, 1 `IDLE` cycle, then the data master is granted. Its write reaches the slave with `we`=1 and `sel`=0xF.
3. **Grant held across beats.** Data master holds `cyc` for 4 `stb` beats while the instruction master requests throughout -> no switch until the data master's `cyc` is low. The instruction master is granted afterwards.
4. **Watchdog expiry.** `TIMEOUT`=8, slave never acks -> the owner's `err` pulses in the 9th `stb` cycle. `wbs_cyc_o` is 0 in that cycle. Release follows `cyc` low.
5. **Ack at the expiry cycle.** `wbs_ack_i` arrives in exactly the expiry cycle -> `ack` is delivered, no `err`, counter returns to 0.
6. **Reset mid-transfer.** Assert `wb_rst_ni`=0 mid-transfer -> all outputs are 0 immediately. After release the state is `IDLE` and the next tie goes to the instruction master.
